// File: rtl/kanagawa_ram_read_streamer.sv
// Streams a (start address, count) command out of a fixed-latency RAM read port onto a
// ready/valid output, using a credit-managed return FIFO to absorb backpressure.
module kanagawa_ram_read_streamer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    output logic [ADDR_WIDTH-1:0] ram_readaddr_out,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    // state | meaning
    // IDLE  | cmd_ready high, waiting for a command
    // ISSUE | one RAM read per cycle while return credit is available
    // DRAIN | all reads issued, waiting for the last-tagged word to be popped

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int IFW = $clog2(READ_LATENCY + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
    localparam logic [ADDR_WIDTH:0] REM_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH:0]     remaining;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_last;
    logic [IFW-1:0]          in_flight;
    logic [DATA_WIDTH:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [FCW-1:0]          fifo_count;
    logic                    accept;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    credit;
    logic                    head_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + IFW'(tag_valid[i]);
        end
    end

    assign accept    = cmd_valid && cmd_ready;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = tag_valid[READ_LATENCY-1];
    // A pop in the same cycle frees a slot, which keeps throughput at one word per cycle.
    assign credit    = (SW'(in_flight) + SW'(fifo_count)) < (SW'(FIFO_DEPTH) + SW'(pop));
    assign issue     = (state == ISSUE) && credit;

    assign ram_readaddr_out = addr;
    assign head_last        = fifo_mem[rd_ptr][DATA_WIDTH];
    assign out_data         = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign out_last         = out_valid && head_last;
    assign busy             = (state != IDLE) || (in_flight != '0) || out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_last[0]  <= issue && (remaining == REM_ONE);
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_count;
                        if (cmd_count != '0) begin
                            state     <= ISSUE;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - REM_ONE;
                        if (remaining == REM_ONE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {tag_last[READ_LATENCY-1], ram_data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule
